// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared controller state type, default response depth and credit-width helper
package sram_ctrl_pkg;
    typedef enum logic {INIT, RUN} ctrl_state_t;
    localparam int RESP_DEPTH_DFLT = 3;
    function automatic int cred_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/sram_resp_fifo.sv
// sram_resp_fifo: DEPTH x WIDTH sync FIFO holding read responses
//   clock, reset_n    clock, async active-low reset (empties the FIFO)
//   push, push_data   write an entry
//   pop               drop the head entry
//   head, count       head entry and current occupancy
module sram_resp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 7,
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    assign head = mem[rp];
    always_ff @(posedge clock)
        if (push) mem[wp] <= push_data;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
            if (pop)  rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
endmodule

// File: rtl/sram_1r1w_port_ctrl.sv
// sram_1r1w_port_ctrl: clears a 1R1W SRAM after reset, then serves read/write requests
//   clock, reset_n                    clock, async active-low reset
//   init_done                         array clear complete
//   rd_req_*                          read request (valid/ready/addr)
//   rd_resp_*                         read response (valid/ready/data), in request order
//   wr_req_*                          write request (valid/ready/addr/data)
//   arr_r_*, arr_w_*                  macro ports; arr_r_data valid the cycle after arr_r_en
module sram_1r1w_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int               DEPTH      = 1024,
    parameter int               WIDTH      = 7,
    parameter int               ADDR_W     = 10,
    parameter int               RESP_DEPTH = RESP_DEPTH_DFLT,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_done,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [WIDTH-1:0]  rd_resp_data,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [WIDTH-1:0]  wr_req_data,
    output logic              arr_r_en,
    output logic [ADDR_W-1:0] arr_r_addr,
    input  logic [WIDTH-1:0]  arr_r_data,
    output logic              arr_w_en,
    output logic [ADDR_W-1:0] arr_w_addr,
    output logic [WIDTH-1:0]  arr_w_data
);
    localparam int CW = cred_w(RESP_DEPTH);
    ctrl_state_t       state, state_d;
    logic [ADDR_W-1:0] init_cnt;
    logic [CW-1:0]     cred, cnt;
    logic              run, accept, pop, rv, fhit;
    logic [WIDTH-1:0]  fdata;
    always_comb begin
        state_d = state;
        if (state == INIT && init_cnt == ADDR_W'(DEPTH - 1)) state_d = RUN;
    end
    assign run           = state == RUN;
    assign init_done     = run;
    assign wr_req_ready  = run;
    assign rd_resp_valid = cnt != '0;
    assign pop           = rd_resp_valid && rd_resp_ready;
    // a pop frees a credit in the same cycle, so a full buffer can still accept
    assign rd_req_ready  = run && (cred != CW'(RESP_DEPTH) || pop);
    assign accept        = rd_req_valid && rd_req_ready;
    assign arr_r_en      = accept;
    assign arr_r_addr    = rd_req_addr;
    assign arr_w_en      = run ? wr_req_valid : 1'b1;
    assign arr_w_addr    = run ? wr_req_addr : init_cnt;
    assign arr_w_data    = run ? wr_req_data : INIT_VALUE;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state    <= INIT;
            init_cnt <= '0;
            cred     <= '0;
            rv       <= 1'b0;
            fhit     <= 1'b0;
            fdata    <= '0;
        end else begin
            state <= state_d;
            if (!run) init_cnt <= init_cnt + 1'b1;
            cred  <= cred + CW'(accept) - CW'(pop);
            rv    <= accept;
            // same-cycle write to the read address wins over whatever the macro returns
            fhit  <= accept && wr_req_valid && wr_req_addr == rd_req_addr;
            fdata <= wr_req_data;
        end
    sram_resp_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(WIDTH), .CNT_W(CW)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rv),
        .push_data (fhit ? fdata : arr_r_data),
        .pop       (pop),
        .head      (rd_resp_data),
        .count     (cnt)
    );
endmodule
